// File: rtl/hnf_txsnp_if.sv
// rtl/hnf_txsnp_if.sv - TXSNP bundle: snoop-generator side handshake plus CHI link-side flit and credit signals
interface hnf_txsnp_if #(
    parameter int MAX_CRD = 15
);
    typedef struct packed {
        logic [3:0]  qos;
        logic [10:0] srcid;
        logic [11:0] txnid;
        logic [10:0] fwdnid;
        logic [11:0] fwdtxnid;
        logic [4:0]  opcode;
        logic [44:0] addr;
        logic        ns;
        logic        donotgotosd;
        logic        rettosrc;
        logic        tracetag;
    } snpflit_t;

    snpflit_t                       txsnpflit;
    logic                           txsnp_valid;
    logic                           txsnp_ready;
    snpflit_t                       TXSNPFLIT;
    logic                           TXSNPFLITV;
    logic                           TXSNPFLITPEND;
    logic                           TXSNPLCRDV;
    logic [$clog2(MAX_CRD+1)-1:0]   txsnp_crd_cnt;
    logic                           txsnp_idle;
    logic                           txsnp_crd_ovf;

    modport master (
        output txsnpflit, txsnp_valid, TXSNPLCRDV,
        input  txsnp_ready, TXSNPFLIT, TXSNPFLITV, TXSNPFLITPEND,
               txsnp_crd_cnt, txsnp_idle, txsnp_crd_ovf
    );

    modport slave (
        input  txsnpflit, txsnp_valid, TXSNPLCRDV,
        output txsnp_ready, TXSNPFLIT, TXSNPFLITV, TXSNPFLITPEND,
               txsnp_crd_cnt, txsnp_idle, txsnp_crd_ovf
    );
endinterface

// File: rtl/hnf_txsnp.sv
// rtl/hnf_txsnp.sv - HN-F TXSNP link layer: snoop FIFO drained onto the link under L-credit flow control
module hnf_txsnp #(
    parameter int DEPTH   = 4,
    parameter int MAX_CRD = 15
) (
    input  logic        clock,
    input  logic        reset,
    hnf_txsnp_if.slave  bus
);
    // Width of hnf_txsnp_if::snpflit_t; kept in step with the interface struct.
    localparam int FLIT_W = 104;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(MAX_CRD + 1);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr, rptr, wptr_nxt, rptr_nxt;
    logic [CW-1:0]     crd;
    logic              empty, full, push, send;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push     = bus.txsnp_valid && !full;
    assign send     = !empty && (crd != '0);
    assign wptr_nxt = wptr + {{AW{1'b0}}, push};
    assign rptr_nxt = rptr + {{AW{1'b0}}, send};

    assign bus.txsnp_ready   = !full;
    assign bus.txsnp_crd_cnt = crd;
    assign bus.txsnp_idle    = empty && !bus.TXSNPFLITV;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= bus.txsnpflit;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr              <= '0;
            rptr              <= '0;
            crd               <= '0;
            bus.txsnp_crd_ovf <= 1'b0;
            bus.TXSNPFLIT     <= '0;
            bus.TXSNPFLITV    <= 1'b0;
            bus.TXSNPFLITPEND <= 1'b0;
        end else begin
            wptr           <= wptr_nxt;
            rptr           <= rptr_nxt;
            bus.TXSNPFLITV <= send;
            bus.TXSNPFLIT  <= send ? mem[rptr[AW-1:0]] : '0;
            // Pending covers both the cycle before a flit and the flit cycle itself.
            bus.TXSNPFLITPEND <= (wptr_nxt != rptr_nxt) || send;
            if (bus.TXSNPLCRDV && !send) begin
                if (crd == CW'(MAX_CRD)) begin
                    bus.txsnp_crd_ovf <= 1'b1;
                end else begin
                    crd <= crd + CW'(1);
                end
            end else if (!bus.TXSNPLCRDV && send) begin
                crd <= crd - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_hnf_txsnp.sv
// tb/tb_hnf_txsnp.sv - self-checking bench for hnf_txsnp with a queue-based reference model
module tb_hnf_txsnp;
    localparam int DEPTH   = 4;
    localparam int MAX_CRD = 15;
    localparam int FW      = 104;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    hnf_txsnp_if #(.MAX_CRD(MAX_CRD)) bus ();
    hnf_txsnp #(.DEPTH(DEPTH), .MAX_CRD(MAX_CRD)) dut (.clock(clock), .reset(reset), .bus(bus));

    logic [FW-1:0] mq [$];
    logic [FW-1:0] m_flit;
    int            m_crd;
    bit            m_ovf, m_v, m_pend;

    task automatic tick();
        bit snd;
        bit acc;
        @(posedge clock);
        if (reset) begin
            mq.delete();
            m_crd = 0; m_ovf = 0; m_v = 0; m_pend = 0; m_flit = '0;
        end else begin
            snd = (mq.size() > 0) && (m_crd > 0);
            acc = bus.txsnp_valid && (mq.size() < DEPTH);
            m_v = snd;
            m_flit = '0;
            if (snd) m_flit = mq.pop_front();
            if (acc) mq.push_back(bus.txsnpflit);
            if (bus.TXSNPLCRDV && !snd && m_crd == MAX_CRD) m_ovf = 1;
            else m_crd = m_crd + int'(bus.TXSNPLCRDV) - int'(snd);
            m_pend = (mq.size() > 0) || snd;
        end
        @(negedge clock);
    endtask

    task automatic set_flit(input logic [11:0] id);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        bus.txsnpflit = r[FW-1:0];
        bus.txsnpflit.txnid = id;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.txsnp_valid = 1'b0;
        bus.TXSNPLCRDV = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_run++;
        if ({bus.TXSNPFLITV, bus.TXSNPFLITPEND, bus.txsnp_ready, bus.txsnp_idle, bus.txsnp_crd_ovf} !== 5'b00110) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00110", {bus.TXSNPFLITV, bus.TXSNPFLITPEND, bus.txsnp_ready, bus.txsnp_idle, bus.txsnp_crd_ovf});
        end
        n_run++;
        if (bus.txsnp_crd_cnt !== 4'd0 || bus.TXSNPFLIT !== '0) begin
            n_fail++;
            $display("FAIL reset_crd_flit: crd %0d flit %h want 0/0", bus.txsnp_crd_cnt, bus.TXSNPFLIT);
        end
    endtask

    task automatic test_credit_gating();
        do_reset();
        bus.txsnp_valid = 1'b1;
        set_flit(12'h005);
        tick();
        bus.txsnp_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_run++;
            if ({bus.TXSNPFLITV, bus.TXSNPFLITPEND, bus.txsnp_idle} !== 3'b010) begin
                n_fail++;
                $display("FAIL gate_wait c%0d: v/pend/idle %b want 010", c, {bus.TXSNPFLITV, bus.TXSNPFLITPEND, bus.txsnp_idle});
            end
        end
        bus.TXSNPLCRDV = 1'b1;
        tick();
        bus.TXSNPLCRDV = 1'b0;
        n_run++;
        if (bus.TXSNPFLITV !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_early: flitv %b want 0", bus.TXSNPFLITV);
        end
        tick();
        n_run++;
        if (bus.TXSNPFLITV !== 1'b1 || bus.TXSNPFLIT.txnid !== 12'h005) begin
            n_fail++;
            $display("FAIL gate_send: flitv %b txnid %h want 1/005", bus.TXSNPFLITV, bus.TXSNPFLIT.txnid);
        end
        n_run++;
        if (bus.txsnp_crd_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL gate_crd: got %0d want 0", bus.txsnp_crd_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.TXSNPLCRDV = 1'b1;
        repeat (3) tick();
        bus.TXSNPLCRDV = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            bus.txsnp_valid = (i <= 3);
            if (i <= 3) set_flit(12'(i));
            tick();
            n_run++;
            if (bus.TXSNPFLITV !== ((i >= 2) && (i <= 4)) ||
                ((i >= 2) && (i <= 4) && bus.TXSNPFLIT.txnid !== 12'(i - 1))) begin
                n_fail++;
                $display("FAIL b2b_t%0d: flitv %b txnid %h want %b/%h", i, bus.TXSNPFLITV, bus.TXSNPFLIT.txnid,
                         (i >= 2) && (i <= 4), 12'(i - 1));
            end
        end
        n_run++;
        if (bus.txsnp_crd_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_crd: got %0d want 0", bus.txsnp_crd_cnt);
        end
    endtask

    task automatic test_full();
        int k;
        bit acc;
        logic [11:0] got [$];
        do_reset();
        k = 0;
        bus.txsnp_valid = 1'b1;
        set_flit(12'h010);
        for (int c = 0; c < 7; c++) begin
            acc = bus.txsnp_ready;
            tick();
            if (acc) begin
                k++;
                set_flit(12'(16 + k));
            end
        end
        n_run++;
        if (k !== 4 || bus.txsnp_ready !== 1'b0 || bus.TXSNPFLITV !== 1'b0) begin
            n_fail++;
            $display("FAIL full_hold: accepts %0d ready %b flitv %b want 4/0/0", k, bus.txsnp_ready, bus.TXSNPFLITV);
        end
        bus.TXSNPLCRDV = 1'b1;
        tick();
        bus.TXSNPLCRDV = 1'b0;
        tick();
        n_run++;
        if (bus.TXSNPFLITV !== 1'b1 || bus.TXSNPFLIT.txnid !== 12'h010 || bus.txsnp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_first: flitv %b txnid %h ready %b want 1/010/1", bus.TXSNPFLITV, bus.TXSNPFLIT.txnid, bus.txsnp_ready);
        end
        tick();
        bus.txsnp_valid = 1'b0;
        for (int c = 0; c < 14; c++) begin
            bus.TXSNPLCRDV = (c < 4);
            tick();
            if (bus.TXSNPFLITV) got.push_back(bus.TXSNPFLIT.txnid);
        end
        n_run++;
        if (got.size() !== 4) begin
            n_fail++;
            $display("FAIL full_drain_cnt: got %0d flits want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_run++;
                if (got[i] !== 12'(17 + i)) begin
                    n_fail++;
                    $display("FAIL full_order%0d: got %h want %h", i, got[i], 12'(17 + i));
                end
            end
        end
    endtask

    task automatic test_simul_return();
        do_reset();
        bus.txsnp_valid = 1'b1;
        set_flit(12'h021);
        tick();
        set_flit(12'h022);
        tick();
        bus.txsnp_valid = 1'b0;
        bus.TXSNPLCRDV = 1'b1;
        tick();
        tick();
        bus.TXSNPLCRDV = 1'b0;
        n_run++;
        if (bus.TXSNPFLITV !== 1'b1 || bus.TXSNPFLIT.txnid !== 12'h021 || bus.txsnp_crd_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL simul_a: flitv %b txnid %h crd %0d want 1/021/1", bus.TXSNPFLITV, bus.TXSNPFLIT.txnid, bus.txsnp_crd_cnt);
        end
        tick();
        n_run++;
        if (bus.TXSNPFLITV !== 1'b1 || bus.TXSNPFLIT.txnid !== 12'h022 || bus.txsnp_crd_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL simul_b: flitv %b txnid %h crd %0d want 1/022/0", bus.TXSNPFLITV, bus.TXSNPFLIT.txnid, bus.txsnp_crd_cnt);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        bus.TXSNPLCRDV = 1'b1;
        repeat (15) tick();
        n_run++;
        if (bus.txsnp_crd_cnt !== 4'd15 || bus.txsnp_crd_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_15: crd %0d ovf %b want 15/0", bus.txsnp_crd_cnt, bus.txsnp_crd_ovf);
        end
        tick();
        bus.TXSNPLCRDV = 1'b0;
        n_run++;
        if (bus.txsnp_crd_cnt !== 4'd15 || bus.txsnp_crd_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_16: crd %0d ovf %b want 15/1", bus.txsnp_crd_cnt, bus.txsnp_crd_ovf);
        end
        repeat (5) tick();
        n_run++;
        if (bus.txsnp_crd_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b want 1", bus.txsnp_crd_ovf);
        end
        do_reset();
        n_run++;
        if (bus.txsnp_crd_ovf !== 1'b0 || bus.txsnp_crd_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf %b crd %0d want 0/0", bus.txsnp_crd_ovf, bus.txsnp_crd_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        bus.txsnp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_flit(12'(48 + i));
            tick();
        end
        bus.txsnp_valid = 1'b0;
        bus.TXSNPLCRDV = 1'b1;
        repeat (2) tick();
        bus.TXSNPLCRDV = 1'b0;
        w = 0;
        while (bus.TXSNPFLITV !== 1'b1 && w < 10) begin
            tick();
            w++;
        end
        n_run++;
        if (bus.TXSNPFLITV !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_wait: flitv %b want 1 within 10 cycles", bus.TXSNPFLITV);
        end
        do_reset();
        n_run++;
        if ({bus.TXSNPFLITV, bus.TXSNPFLITPEND, bus.txsnp_ready, bus.txsnp_idle} !== 4'b0011 || bus.txsnp_crd_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL rstmid_state: v/pend/ready/idle %b crd %0d want 0011/0",
                     {bus.TXSNPFLITV, bus.TXSNPFLITPEND, bus.txsnp_ready, bus.txsnp_idle}, bus.txsnp_crd_cnt);
        end
        for (int c = 0; c < 8; c++) begin
            bus.TXSNPLCRDV = (c < 3);
            tick();
            n_run++;
            if (bus.TXSNPFLITV !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_stale c%0d: flitv %b txnid %h want 0", c, bus.TXSNPFLITV, bus.TXSNPFLIT.txnid);
            end
        end
        bus.TXSNPLCRDV = 1'b0;
    endtask

    task automatic test_random();
        logic [10:0] obs, exp;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!(bus.txsnp_valid && !bus.txsnp_ready)) begin
                bus.txsnp_valid = $urandom_range(0, 1) == 1;
                set_flit(12'($urandom));
            end
            bus.TXSNPLCRDV = ($urandom_range(0, 9) < 3);
            tick();
            obs = {bus.TXSNPFLITV, bus.TXSNPFLITPEND, bus.txsnp_ready, bus.txsnp_idle, bus.txsnp_crd_ovf,
                   2'b00, bus.txsnp_crd_cnt};
            exp = {m_v, m_pend, mq.size() < DEPTH, (mq.size() == 0) && !m_v, m_ovf, 2'b00, 4'(m_crd)};
            n_run++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL rand_ctl c%0d: got %b want %b", c, obs, exp);
            end
            n_run++;
            if (bus.TXSNPFLIT !== m_flit) begin
                n_fail++;
                $display("FAIL rand_flit c%0d: got %h want %h", c, bus.TXSNPFLIT, m_flit);
            end
        end
        bus.txsnp_valid = 1'b0;
        bus.TXSNPLCRDV = 1'b0;
    endtask

    initial begin
        bus.txsnp_valid = 1'b0;
        bus.TXSNPLCRDV = 1'b0;
        bus.txsnpflit = '0;
        test_reset();
        test_credit_gating();
        test_back_to_back();
        test_full();
        test_simul_return();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
